panda_lsu: RTL and testbench
============================

# panda_lsu

Load/store unit sitting directly upstream of `panda_ram` in the Panda core data path. Accepts one byte/halfword/word memory request per cycle from the execute stage over a valid/ready handshake, and converts it into `panda_ram` port activity: word address, byte write enables and lane-replicated write data. Load data returns one cycle later from the RAM and is lane-aligned and sign- or zero-extended. Misaligned and out-of-range accesses are rejected without touching the RAM and flagged on the response.

## Interface
- `DataWidth`, 32: data width; only 32 is supported.
- `Depth`, 64: RAM depth in words. The byte address space is `0 .. Depth*4-1`.
- `clk_i` input 1: clock; all state updates on the rising edge.
- `rst_ni` input 1: reset, asynchronous, active-low.
- `req_valid_i` input 1: request valid.
- `req_ready_o` output 1: request ready. A request is accepted when valid && ready.
- `req_we_i` input 1: 1 = store, 0 = load.
- `req_size_i` input 2: 0 = byte, 1 = half, 2 = word, 3 = illegal.
- `req_unsigned_i` input 1: zero-extend load data (ignored for stores).
- `req_addr_i` input 32: byte address.
- `req_wdata_i` input 32: store data, right-aligned.
- `rsp_valid_o` output 1: response valid.
- `rsp_ready_i` input 1: response consumed when valid && ready.
- `rsp_rdata_o` output 32: load result; 0 for stores and errors.
- `rsp_err_o` output 1: misaligned, illegal-size or out-of-range access.
- `ram_ce_o` output 1: to `panda_ram` `ce_i`.
- `ram_we_o` output 4: to `we_i`, byte enables.
- `ram_addr_o` output $clog2(Depth): to `addr_i`, equal to `req_addr_i[$clog2(Depth)+1:2]`.
- `ram_wdata_o` output 32: to `data_i`.
- `ram_rdata_i` input 32: from `data_o`; valid one cycle after a `ce_i` read.

## Operation
- **States:** IDLE, RSP_LIVE, RSP_HELD. Reset state is IDLE.
- **Error check (combinational, at acceptance):** an access is an error when any of the following holds:
  - size is 3;
  - half access with `addr[0]` = 1;
  - word access with `addr[1:0]` != 0;
  - `addr` >= Depth*4.
- **RAM drive:** `ram_ce_o` = accept && !err. `ram_we_o` is 0 for loads and errors. For stores:
  - byte: `0001 << addr[1:0]`, data = byte replicated ×4;
  - half: `0011 << (2*addr[1])`, data = half replicated ×2;
  - word: `1111`, data as given.
- **Registered at acceptance:** offset `addr[1:0]`, size, unsigned, we, err.
- **Load format:**
  - Select lane `ram_rdata_i >> (8*offset)`.
  - Byte: bits [7:0], extended from bit 7. Half: bits [15:0], extended from bit 15.
  - Word: unchanged.
  - Extension is zero-extension when unsigned, otherwise sign-extension.
- **Transitions:**
  - IDLE: accept → RSP_LIVE.
  - RSP_LIVE: `rsp_valid_o` = 1. `rsp_rdata_o` is the formatted live `ram_rdata_i` (loads) or 0.
    - If `rsp_ready_i`: a new accept in the same cycle goes to RSP_LIVE, otherwise IDLE.
    - If !`rsp_ready_i`: capture the formatted data into the hold register and go to RSP_HELD.
  - RSP_HELD: `rsp_valid_o` = 1 and data comes from the hold register. On `rsp_ready_i`, same transitions as RSP_LIVE.
- `req_ready_o` = (state == IDLE) || `rsp_ready_i`. At most one outstanding response; the RAM is never accessed while a response is stalled.
- `rsp_err_o` and `rsp_rdata_o` are 0 whenever `rsp_valid_o` = 0.

## Timing
- Reset values:
  - state IDLE;
  - `rsp_valid_o` 0, `rsp_err_o` 0, `rsp_rdata_o` 0;
  - `ram_ce_o` 0, `ram_we_o` 0;
  - hold register 0.
- While `rst_ni` is low, `ram_ce_o` and `ram_we_o` are forced to 0 even if `req_valid_i` is high.
- Request-to-RAM path is combinational: the RAM samples on the same edge that accepts the request.
- Latency: the response is valid in the cycle after acceptance for loads, stores and errors alike.
- Throughput: one request per cycle while `rsp_ready_i` stays high.
- Store writes complete at the accepting edge. The response only acknowledges the store.
- Reset asserted mid-operation: any pending response is discarded, state goes to IDLE, and no RAM access is generated after reset deasserts until a new accept.

## Test plan
- **Word store:** store word 0xABCDEF89 @0xA0 → in the accept cycle `ram_ce_o` = 1, `ram_we_o` = 1111, `ram_addr_o` = 40, `ram_wdata_o` = 0xABCDEF89. Next cycle `rsp_valid_o` = 1, `rsp_err_o` = 0, `rsp_rdata_o` = 0.
- **Sub-word stores:**
  - Store byte 0x89 @0xA7 → `ram_we_o` = 1000, `ram_addr_o` = 41, `ram_wdata_o` = 0x89898989.
  - Store half 0xEF89 @0xAA → `ram_we_o` = 1100, `ram_wdata_o` = 0xEF89EF89.
- **Loads after the word store:**
  - Signed byte @0xA0 → 0xFFFFFF89; unsigned → 0x00000089.
  - Signed half @0xA2 → 0xFFFFABCD.
  - Word @0xA0 → 0xABCDEF89.
  - Back-to-back loads with `rsp_ready_i` = 1 give one response per cycle.
- **Errors:** each of the following → `ram_ce_o` stays 0; next cycle `rsp_err_o` = 1 and `rsp_rdata_o` = 0.
  - Half @0xA1.
  - Word @0xA2.
  - Size 3.
  - Word @0x100.
- **Backpressure:** load word @0xA0 with `rsp_ready_i` = 0 for 3 cycles while `ram_rdata_i` is driven to 0xDEADBEEF. Required: `rsp_rdata_o` holds 0xABCDEF89, `req_ready_o` = 0, `ram_ce_o` = 0. Raise `rsp_ready_i` with a new request pending → accepted in that cycle.
- **Reset mid-operation:** assert `rst_ni` low while in RSP_HELD → `rsp_valid_o` = 0 immediately and state IDLE. After release, no response appears until a new accept.

Source files
------------

// File: rtl/panda_lsu.sv
// rtl/panda_lsu.sv - load/store unit between execute stage and panda_ram
module panda_lsu #(
  parameter int DataWidth = 32,
  parameter int Depth     = 64
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     req_valid_i,
  output logic                     req_ready_o,
  input  logic                     req_we_i,
  input  logic [1:0]               req_size_i,
  input  logic                     req_unsigned_i,
  input  logic [31:0]              req_addr_i,
  input  logic [DataWidth-1:0]     req_wdata_i,
  output logic                     rsp_valid_o,
  input  logic                     rsp_ready_i,
  output logic [DataWidth-1:0]     rsp_rdata_o,
  output logic                     rsp_err_o,
  output logic                     ram_ce_o,
  output logic [3:0]               ram_we_o,
  output logic [$clog2(Depth)-1:0] ram_addr_o,
  output logic [DataWidth-1:0]     ram_wdata_o,
  input  logic [DataWidth-1:0]     ram_rdata_i
);

  localparam int          AddrW     = $clog2(Depth);
  localparam logic [31:0] ByteLimit = 32'(Depth * 4);

  localparam logic [1:0] SIZE_B = 2'd0;
  localparam logic [1:0] SIZE_H = 2'd1;
  localparam logic [1:0] SIZE_W = 2'd2;

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] RSP_LIVE = 2'd1;
  localparam logic [1:0] RSP_HELD = 2'd2;

  logic [1:0]           state_q;
  logic                 accept;
  logic                 req_err;
  logic                 ram_access;
  logic [1:0]           off_q;
  logic [1:0]           size_q;
  logic                 uns_q;
  logic                 we_q;
  logic                 err_q;
  logic [DataWidth-1:0] hold_q;
  logic [DataWidth-1:0] live_data;

  // A new request can only be taken when the previous response leaves this cycle.
  assign req_ready_o = (state_q == IDLE) || rsp_ready_i;
  assign accept      = req_valid_i && req_ready_o;

  // Classify the incoming request: illegal size, misalignment, beyond the RAM.
  always_comb begin
    req_err = 1'b0;
    case (req_size_i)
      SIZE_B:  req_err = 1'b0;
      SIZE_H:  req_err = req_addr_i[0];
      SIZE_W:  req_err = |req_addr_i[1:0];
      default: req_err = 1'b1;
    endcase
    if (req_addr_i >= ByteLimit) begin
      req_err = 1'b1;
    end
  end

  // Reset gating keeps the RAM quiet while rst_ni is low even though IDLE reports ready.
  assign ram_access = accept && !req_err && rst_ni;
  assign ram_ce_o   = ram_access;
  assign ram_addr_o = req_addr_i[AddrW+1:2];

  // Byte enables and lane-replicated store data; enables stay clear for loads and errors.
  always_comb begin
    ram_we_o    = 4'b0000;
    ram_wdata_o = req_wdata_i;
    case (req_size_i)
      SIZE_B: begin
        ram_we_o    = 4'b0001 << req_addr_i[1:0];
        ram_wdata_o = {4{req_wdata_i[7:0]}};
      end
      SIZE_H: begin
        ram_we_o    = 4'b0011 << {req_addr_i[1], 1'b0};
        ram_wdata_o = {2{req_wdata_i[15:0]}};
      end
      SIZE_W:  ram_we_o = 4'b1111;
      default: ram_we_o = 4'b0000;
    endcase
    if (!(ram_access && req_we_i)) begin
      ram_we_o = 4'b0000;
    end
  end

  // Align the addressed lane to bit 0 and extend it to the full width.
  function automatic logic [DataWidth-1:0] fmt_load(
    input logic [DataWidth-1:0] raw,
    input logic [1:0]           off,
    input logic [1:0]           size,
    input logic                 uns
  );
    logic [DataWidth-1:0] lane;
    lane = raw >> {off, 3'b000};
    case (size)
      SIZE_B:  fmt_load = {{24{~uns & lane[7]}}, lane[7:0]};
      SIZE_H:  fmt_load = {{16{~uns & lane[15]}}, lane[15:0]};
      default: fmt_load = lane;
    endcase
  endfunction

  // Stores and rejected accesses answer with zero data.
  assign live_data = (we_q || err_q) ? '0 : fmt_load(ram_rdata_i, off_q, size_q, uns_q);

  // Response FSM, request attributes and stall hold register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      off_q   <= 2'd0;
      size_q  <= 2'd0;
      uns_q   <= 1'b0;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
      hold_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            state_q <= RSP_LIVE;
          end
        end
        RSP_LIVE: begin
          if (rsp_ready_i) begin
            state_q <= accept ? RSP_LIVE : IDLE;
          end else begin
            // RAM output is only valid for one cycle, so park it before it changes.
            hold_q  <= live_data;
            state_q <= RSP_HELD;
          end
        end
        RSP_HELD: begin
          if (rsp_ready_i) begin
            state_q <= accept ? RSP_LIVE : IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
      if (accept) begin
        off_q  <= req_addr_i[1:0];
        size_q <= req_size_i;
        uns_q  <= req_unsigned_i;
        we_q   <= req_we_i;
        err_q  <= req_err;
      end
    end
  end

  // Response outputs: live RAM data first cycle, hold register while stalled, zero when idle.
  always_comb begin
    rsp_valid_o = 1'b0;
    rsp_rdata_o = '0;
    rsp_err_o   = 1'b0;
    case (state_q)
      RSP_LIVE: begin
        rsp_valid_o = 1'b1;
        rsp_rdata_o = live_data;
        rsp_err_o   = err_q;
      end
      RSP_HELD: begin
        rsp_valid_o = 1'b1;
        rsp_rdata_o = hold_q;
        rsp_err_o   = err_q;
      end
      default: begin
        rsp_valid_o = 1'b0;
        rsp_rdata_o = '0;
        rsp_err_o   = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_panda_lsu.sv
// tb/tb_panda_lsu.sv - self-checking bench for panda_lsu with byte-level memory model
module tb_panda_lsu;

  logic        clk = 1'b0;
  logic        rst_ni;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        ram_ce;
  logic [3:0]  ram_we;
  logic [5:0]  ram_addr;
  logic [31:0] ram_wdata;
  logic [31:0] ram_rdata;

  // panda_ram stand-in
  logic [31:0] ram [0:63];
  logic [31:0] ram_q;
  logic        ram_clr;
  logic        force_en;
  logic [31:0] force_val;

  // reference model state
  logic [7:0]  mem_b [0:255];
  logic        pend_valid;
  logic        pend_err;
  logic [31:0] pend_data;

  int checks = 0;
  int errors = 0;

  logic        obs_ce;
  logic [3:0]  obs_we;
  logic [5:0]  obs_addr;
  logic [31:0] obs_wdata;
  logic        obs_ready;

  panda_lsu #(.DataWidth(32), .Depth(64)) dut (
    .clk_i          (clk),
    .rst_ni         (rst_ni),
    .req_valid_i    (req_valid),
    .req_ready_o    (req_ready),
    .req_we_i       (req_we),
    .req_size_i     (req_size),
    .req_unsigned_i (req_unsigned),
    .req_addr_i     (req_addr),
    .req_wdata_i    (req_wdata),
    .rsp_valid_o    (rsp_valid),
    .rsp_ready_i    (rsp_ready),
    .rsp_rdata_o    (rsp_rdata),
    .rsp_err_o      (rsp_err),
    .ram_ce_o       (ram_ce),
    .ram_we_o       (ram_we),
    .ram_addr_o     (ram_addr),
    .ram_wdata_o    (ram_wdata),
    .ram_rdata_i    (ram_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ram_clr) begin
      for (int i = 0; i < 64; i++) ram[i] <= 32'd0;
      ram_q <= 32'd0;
    end else if (ram_ce) begin
      for (int b = 0; b < 4; b++)
        if (ram_we[b]) ram[ram_addr][8*b +: 8] <= ram_wdata[8*b +: 8];
      ram_q <= ram[ram_addr];
    end
  end

  assign ram_rdata = force_en ? force_val : ram_q;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive request, check against the model, advance model, return at negedge+1.
  task automatic cyc(input logic v, input logic we, input logic [1:0] sz, input logic uns,
                     input logic [31:0] addr, input logic [31:0] wd, input logic rdy);
    int          nb;
    logic        exp_err;
    logic        exp_ready;
    logic        exp_acc;
    logic        exp_ce;
    logic [3:0]  exp_we;
    logic [31:0] exp_wd;
    logic [31:0] val;
    req_valid    = v;
    req_we       = we;
    req_size     = sz;
    req_unsigned = uns;
    req_addr     = addr;
    req_wdata    = wd;
    rsp_ready    = rdy;
    #1;
    nb        = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    exp_err   = (sz == 2'd3) || ((int'(addr[1:0]) % nb) != 0) || (addr >= 32'd256);
    exp_ready = !pend_valid || rdy;
    exp_acc   = v && exp_ready;
    exp_ce    = exp_acc && !exp_err;
    chk("rsp_valid", {31'd0, rsp_valid}, {31'd0, pend_valid});
    chk("rsp_err", {31'd0, rsp_err}, {31'd0, pend_valid && pend_err});
    chk("rsp_rdata", rsp_rdata, pend_valid ? pend_data : 32'd0);
    chk("req_ready", {31'd0, req_ready}, {31'd0, exp_ready});
    chk("ram_ce", {31'd0, ram_ce}, {31'd0, exp_ce});
    exp_we = 4'b0000;
    exp_wd = 32'd0;
    if (exp_ce && we) begin
      for (int k = 0; k < nb; k++) exp_we[(int'(addr[1:0]) + k) % 4] = 1'b1;
      for (int j = 0; j < 4; j++) exp_wd[8*j +: 8] = wd[8*(j % nb) +: 8];
      chk("ram_wdata", ram_wdata, exp_wd);
    end
    chk("ram_we", {28'd0, ram_we}, {28'd0, exp_we});
    if (exp_ce) chk("ram_addr", {26'd0, ram_addr}, {26'd0, addr[7:2]});
    obs_ce    = ram_ce;
    obs_we    = ram_we;
    obs_addr  = ram_addr;
    obs_wdata = ram_wdata;
    obs_ready = req_ready;
    if (pend_valid && rdy) pend_valid = 1'b0;
    if (exp_acc) begin
      pend_valid = 1'b1;
      pend_err   = exp_err;
      pend_data  = 32'd0;
      if (!exp_err && !we) begin
        val = 32'd0;
        for (int k = 0; k < nb; k++) val = val | (32'(mem_b[int'(addr[7:0]) + k]) << (8*k));
        if (!uns && nb < 4 && val[8*nb-1]) val = val | ~((32'd1 << (8*nb)) - 32'd1);
        pend_data = val;
      end
      if (!exp_err && we)
        for (int k = 0; k < nb; k++) mem_b[int'(addr[7:0]) + k] = wd[8*k +: 8];
    end
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  initial begin
    logic        r_v, r_we, r_uns, r_rdy;
    logic [1:0]  r_sz;
    logic [31:0] r_addr;
    int          r_nb;

    for (int i = 0; i < 256; i++) mem_b[i] = 8'd0;
    pend_valid   = 1'b0;
    pend_err     = 1'b0;
    pend_data    = 32'd0;
    force_en     = 1'b0;
    force_val    = 32'd0;
    ram_clr      = 1'b1;
    rst_ni       = 1'b0;
    req_valid    = 1'b1;
    req_we       = 1'b1;
    req_size     = 2'd2;
    req_unsigned = 1'b0;
    req_addr     = 32'hA0;
    req_wdata    = 32'h12345678;
    rsp_ready    = 1'b1;

    // reset state, with a valid store request held at the inputs
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    chk("reset_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("reset_rsp_err", {31'd0, rsp_err}, 32'd0);
    chk("reset_rsp_rdata", rsp_rdata, 32'd0);
    chk("reset_ram_ce", {31'd0, ram_ce}, 32'd0);
    chk("reset_ram_we", {28'd0, ram_we}, 32'd0);
    @(negedge clk);
    rst_ni    = 1'b1;
    ram_clr   = 1'b0;
    req_valid = 1'b0;
    #1;

    // word store
    cyc(1'b1, 1'b1, 2'd2, 1'b0, 32'hA0, 32'hABCDEF89, 1'b1);
    chk("wst_ce", {31'd0, obs_ce}, 32'd1);
    chk("wst_we", {28'd0, obs_we}, 32'hF);
    chk("wst_addr", {26'd0, obs_addr}, 32'd40);
    chk("wst_wdata", obs_wdata, 32'hABCDEF89);
    chk("wst_rsp_valid", {31'd0, rsp_valid}, 32'd1);
    chk("wst_rsp_err", {31'd0, rsp_err}, 32'd0);
    chk("wst_rsp_rdata", rsp_rdata, 32'd0);

    // sub-word stores
    cyc(1'b1, 1'b1, 2'd0, 1'b0, 32'hA7, 32'h00000089, 1'b1);
    chk("bst_we", {28'd0, obs_we}, 32'h8);
    chk("bst_addr", {26'd0, obs_addr}, 32'd41);
    chk("bst_wdata", obs_wdata, 32'h89898989);
    cyc(1'b1, 1'b1, 2'd1, 1'b0, 32'hAA, 32'h0000EF89, 1'b1);
    chk("hst_we", {28'd0, obs_we}, 32'hC);
    chk("hst_wdata", obs_wdata, 32'hEF89EF89);

    // back-to-back loads
    cyc(1'b1, 1'b0, 2'd0, 1'b0, 32'hA0, 32'd0, 1'b1);
    chk("ldb_s", rsp_rdata, 32'hFFFFFF89);
    cyc(1'b1, 1'b0, 2'd0, 1'b1, 32'hA0, 32'd0, 1'b1);
    chk("ldb_u", rsp_rdata, 32'h00000089);
    cyc(1'b1, 1'b0, 2'd1, 1'b0, 32'hA2, 32'd0, 1'b1);
    chk("ldh_s", rsp_rdata, 32'hFFFFABCD);
    cyc(1'b1, 1'b0, 2'd2, 1'b0, 32'hA0, 32'd0, 1'b1);
    chk("ldw", rsp_rdata, 32'hABCDEF89);
    chk("ldw_b2b_ce", {31'd0, obs_ce}, 32'd1);

    // rejected accesses
    cyc(1'b1, 1'b0, 2'd1, 1'b0, 32'hA1, 32'd0, 1'b1);
    chk("err_half_ce", {31'd0, obs_ce}, 32'd0);
    chk("err_half_flag", {31'd0, rsp_err}, 32'd1);
    cyc(1'b1, 1'b0, 2'd2, 1'b0, 32'hA2, 32'd0, 1'b1);
    chk("err_word_ce", {31'd0, obs_ce}, 32'd0);
    chk("err_word_flag", {31'd0, rsp_err}, 32'd1);
    cyc(1'b1, 1'b1, 2'd3, 1'b0, 32'hA0, 32'hFFFFFFFF, 1'b1);
    chk("err_size_ce", {31'd0, obs_ce}, 32'd0);
    chk("err_size_flag", {31'd0, rsp_err}, 32'd1);
    cyc(1'b1, 1'b0, 2'd2, 1'b0, 32'h100, 32'd0, 1'b1);
    chk("err_range_ce", {31'd0, obs_ce}, 32'd0);
    chk("err_range_flag", {31'd0, rsp_err}, 32'd1);
    chk("err_range_rdata", rsp_rdata, 32'd0);
    cyc(1'b0, 1'b0, 2'd0, 1'b0, 32'd0, 32'd0, 1'b1);

    // backpressure
    cyc(1'b1, 1'b0, 2'd2, 1'b0, 32'hA0, 32'd0, 1'b0);
    cyc(1'b0, 1'b0, 2'd0, 1'b0, 32'd0, 32'd0, 1'b0);
    force_en  = 1'b1;
    force_val = 32'hDEADBEEF;
    for (int s = 0; s < 2; s++) begin
      cyc(1'b1, 1'b0, 2'd2, 1'b0, 32'hA4, 32'd0, 1'b0);
      chk("bp_ready", {31'd0, obs_ready}, 32'd0);
      chk("bp_ce", {31'd0, obs_ce}, 32'd0);
      chk("bp_hold", rsp_rdata, 32'hABCDEF89);
    end
    force_en = 1'b0;
    cyc(1'b1, 1'b0, 2'd2, 1'b0, 32'hA0, 32'd0, 1'b1);
    chk("bp_release_ready", {31'd0, obs_ready}, 32'd1);
    chk("bp_release_ce", {31'd0, obs_ce}, 32'd1);
    chk("bp_release_rdata", rsp_rdata, 32'hABCDEF89);

    // reset while a response is held
    cyc(1'b0, 1'b0, 2'd0, 1'b0, 32'd0, 32'd0, 1'b0);
    rst_ni    = 1'b0;
    req_valid = 1'b1;
    req_we    = 1'b1;
    req_size  = 2'd2;
    req_addr  = 32'hA0;
    rsp_ready = 1'b1;
    #1;
    chk("midrst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("midrst_rsp_rdata", rsp_rdata, 32'd0);
    chk("midrst_ram_ce", {31'd0, ram_ce}, 32'd0);
    chk("midrst_ram_we", {28'd0, ram_we}, 32'd0);
    pend_valid = 1'b0;
    @(negedge clk);
    rst_ni    = 1'b1;
    req_valid = 1'b0;
    #1;
    for (int s = 0; s < 3; s++) begin
      cyc(1'b0, 1'b0, 2'd0, 1'b0, 32'd0, 32'd0, 1'b1);
      chk("postrst_quiet", {31'd0, rsp_valid}, 32'd0);
    end
    cyc(1'b1, 1'b0, 2'd2, 1'b0, 32'hA0, 32'd0, 1'b1);
    chk("postrst_load", rsp_rdata, 32'hABCDEF89);

    // randomized traffic against the byte model
    for (int n = 0; n < 400; n++) begin
      r_v   = ($urandom_range(0, 3) != 0);
      r_we  = $urandom_range(0, 1) != 0;
      r_uns = $urandom_range(0, 1) != 0;
      r_rdy = ($urandom_range(0, 3) != 0);
      case ($urandom_range(0, 9))
        0, 1, 2: r_sz = 2'd0;
        3, 4, 5: r_sz = 2'd1;
        6, 7, 8: r_sz = 2'd2;
        default: r_sz = 2'd3;
      endcase
      r_nb   = (r_sz == 2'd0) ? 1 : (r_sz == 2'd1) ? 2 : 4;
      r_addr = 32'($urandom_range(0, 255));
      if ($urandom_range(0, 4) != 0) r_addr = r_addr & ~32'(r_nb - 1);
      if ($urandom_range(0, 15) == 0) r_addr = 32'd256 + 32'($urandom_range(0, 1000));
      cyc(r_v, r_we, r_sz, r_uns, r_addr, $urandom, r_rdy);
    end
    cyc(1'b0, 1'b0, 2'd0, 1'b0, 32'd0, 32'd0, 1'b1);
    cyc(1'b0, 1'b0, 2'd0, 1'b0, 32'd0, 32'd0, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
